adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched_pkg.sv | 16 +
 rtl/adder_sched_rr_arbiter.sv | 34 +++
 rtl/adder_sched.sv | 136 +++++++++++++
 tb/tb_adder_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared state encoding and default sizing for the adder scheduler.
package adder_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_NREQ   = 4;
   localparam int DEF_SETTLE = 2;
   localparam int DEF_TMO    = 16;

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter
   import adder_sched_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic             valid
);

   localparam logic [PTR_W:0] NREQ_V = (PTR_W+1)'(NREQ);

   logic [PTR_W:0] pos;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      pos   = '0;
      for (int i = 0; i < NREQ; i++) begin
         pos = {1'b0, ptr} + (PTR_W+1)'(i);
         if (pos >= NREQ_V) begin
            pos = pos - NREQ_V;
         end
         if (!valid && req[pos[PTR_W-1:0]]) begin
            grant[pos[PTR_W-1:0]] = 1'b1;
            valid                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_sched.sv
// Time-shares one external adder among NREQ requesters with round-robin
// arbitration, a settle window before trusting add_done, and a timeout.
module adder_sched
   import adder_sched_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NREQ   = DEF_NREQ,
   parameter int SETTLE = DEF_SETTLE,
   parameter int TMO    = DEF_TMO
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] op_a,
   input  logic [NREQ*WIDTH-1:0] op_b,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      result,
   output logic                  err,
   output logic                  busy,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   output logic                  add_start,
   input  logic [WIDTH-1:0]      add_sum,
   input  logic                  add_done
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(TMO);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TMO - 2);
   localparam logic [PTR_W-1:0] PTR_MAX     = PTR_W'(NREQ - 1);

   state_t state, state_nx;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] grant_idx;
   logic [NREQ-1:0]  grant_oh;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] result_q;
   logic             err_q;

   logic [NREQ-1:0]  arb_grant;
   logic             arb_valid;
   logic [PTR_W-1:0] arb_idx;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             done_ok;
   logic             tmo_hit;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   always_comb begin
      arb_idx = '0;
      sel_a   = '0;
      sel_b   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) begin
            arb_idx = PTR_W'(i);
            sel_a   = op_a[i*WIDTH +: WIDTH];
            sel_b   = op_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // done is only trusted once the settle window has elapsed; it wins over timeout
   always_comb begin
      state_nx = state;
      done_ok  = (cnt >= SETTLE_LAST) && add_done;
      tmo_hit  = (cnt == TMO_LAST);
      unique case (state)
         IDLE:    if (arb_valid) state_nx = LAUNCH;
         LAUNCH:  state_nx = WAIT;
         WAIT:    if (done_ok || tmo_hit) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         grant_idx <= '0;
         grant_oh  <= '0;
         cnt       <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant_idx <= arb_idx;
                  grant_oh  <= arb_grant;
                  add_a     <= sel_a;
                  add_b     <= sel_b;
               end
            end
            LAUNCH: cnt <= '0;
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (done_ok) begin
                  result_q <= add_sum;
                  err_q    <= 1'b0;
               end else if (tmo_hit) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end
            end
            RESP: begin
               ptr      <= (grant_idx == PTR_MAX) ? '0 : grant_idx + 1'b1;
               result_q <= '0;
               err_q    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign add_start = (state == LAUNCH);
   assign ack       = (state == RESP) ? grant_oh : '0;
   assign result    = result_q;
   assign err       = err_q;

endmodule

// File: tb/tb_adder_sched.sv
// Bench for adder_sched: behavioural shared adder, table of single
// transactions, plus round-robin, timeout and mid-transaction reset sequences.
module tb_adder_sched;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] op_a = '0;
   logic [N*W-1:0] op_b = '0;
   logic [N-1:0]   ack;
   logic [W-1:0]   result;
   logic           err;
   logic           busy;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic           add_start;
   logic [W-1:0]   add_sum;
   logic           add_done;

   adder_sched #(
      .WIDTH  (W),
      .NREQ   (N),
      .SETTLE (2),
      .TMO    (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .ack       (ack),
      .result    (result),
      .err       (err),
      .busy      (busy),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_start (add_start),
      .add_sum   (add_sum),
      .add_done  (add_done)
   );

   always #5 clk = ~clk;

   // external adder: done rises lat cycles after the start pulse
   logic done_en = 1'b1;
   int   lat = 0;
   logic running = 1'b0;
   int   busy_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         running  <= 1'b0;
         busy_cnt <= 0;
      end else if (add_start) begin
         running  <= 1'b1;
         busy_cnt <= 0;
      end else if (|ack) begin
         running <= 1'b0;
      end else if (running) begin
         busy_cnt <= busy_cnt + 1;
      end
   end

   assign add_done = done_en && running && (busy_cnt >= lat);
   assign add_sum  = add_a + add_b;

   typedef struct {
      logic [N-1:0] ack;
      logic [W-1:0] res;
      logic         err;
   } exp_t;

   typedef struct {
      int           rid;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      logic         en;
      logic [W-1:0] res;
      logic         err;
      int           cyc;
   } vec_t;

   exp_t sb[$];
   exp_t e_mon;
   exp_t e_drv;
   vec_t vecs[8];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ack"}, 32'(ack), 0);
      chk({tag, "_result"}, 32'(result), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_add_start"}, 32'(add_start), 0);
      chk({tag, "_add_a"}, 32'(add_a), 0);
      chk({tag, "_add_b"}, 32'(add_b), 0);
   endtask

   task automatic push_exp(input logic [N-1:0] a, input logic [W-1:0] r, input logic e);
      e_drv.ack = a;
      e_drv.res = r;
      e_drv.err = e;
      sb.push_back(e_drv);
   endtask

   task automatic wait_ack(input int bound, output int cyc, output logic [N-1:0] got);
      cyc = 0;
      got = '0;
      for (int n = 1; n <= bound; n++) begin
         @(negedge clk);
         if (ack != '0) begin
            cyc = n;
            got = ack;
            break;
         end
      end
      if (got == '0) begin
         tests++;
         fails++;
         $display("FAIL ack_wait: got no ack within %0d cycles, expected an ack", bound);
      end
   endtask

   logic prev_start = 1'b0;
   int   start_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         prev_start = 1'b0;
         start_cnt  = 0;
      end else begin
         if (add_start) begin
            chk("add_start_single", 32'(prev_start), 0);
            start_cnt++;
         end
         prev_start = add_start;
         if (ack != '0) begin
            chk("starts_per_txn", 32'(start_cnt), 1);
            start_cnt = 0;
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ack: got %b expected none", ack);
            end else begin
               e_mon = sb.pop_front();
               chk("ack", 32'(ack), 32'(e_mon.ack));
               chk("result", 32'(result), 32'(e_mon.res));
               chk("err", 32'(err), 32'(e_mon.err));
            end
         end else begin
            chk("idle_result", 32'(result), 0);
            chk("idle_err", 32'(err), 0);
         end
      end
   end

   logic [W-1:0] sa [4];
   logic [W-1:0] sbv[4];
   logic [W-1:0] sr [4];
   int           cyc;
   logic [N-1:0] got;

   initial begin
      //          rid  a      b      lat en    res    err   cyc
      vecs[0] = '{0, 8'h03, 8'h05, 0, 1'b1, 8'h08, 1'b0, 4};
      vecs[1] = '{2, 8'hFF, 8'h01, 0, 1'b1, 8'h00, 1'b0, 4};
      vecs[2] = '{1, 8'h80, 8'h80, 1, 1'b1, 8'h00, 1'b0, 4};
      vecs[3] = '{3, 8'h7F, 8'h01, 3, 1'b1, 8'h80, 1'b0, 6};
      vecs[4] = '{0, 8'hAA, 8'h55, 5, 1'b1, 8'hFF, 1'b0, 8};
      vecs[5] = '{0, 8'h12, 8'h34, 0, 1'b0, 8'h00, 1'b1, 17};
      vecs[6] = '{0, 8'h12, 8'h34, 2, 1'b1, 8'h46, 1'b0, 5};
      vecs[7] = '{3, 8'd200, 8'd100, 0, 1'b1, 8'h2C, 1'b0, 4};

      sa  = '{8'd1, 8'd20, 8'd100, 8'd250};
      sbv = '{8'd2, 8'd30, 8'd50, 8'd10};
      sr  = '{8'd3, 8'd50, 8'd150, 8'd4};

      #2 rst = 1'b1;
      #1 chk_reset("por");

      // all four requesting from reset, each dropped after its own ack
      for (int i = 0; i < N; i++) begin
         op_a[i*W +: W] = sa[i];
         op_b[i*W +: W] = sbv[i];
      end
      req = 4'b1111;
      push_exp(4'b0001, sr[0], 1'b0);
      push_exp(4'b0010, sr[1], 1'b0);
      push_exp(4'b0100, sr[2], 1'b0);
      push_exp(4'b1000, sr[3], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(40, cyc, got);
         req = req & ~got;
      end

      @(negedge clk);
      req = 4'b1001;
      push_exp(4'b0001, sr[0], 1'b0);
      push_exp(4'b1000, sr[3], 1'b0);
      for (int k = 0; k < 2; k++) begin
         wait_ack(40, cyc, got);
         req = req & ~got;
      end

      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         op_a[vecs[v].rid*W +: W] = vecs[v].a;
         op_b[vecs[v].rid*W +: W] = vecs[v].b;
         lat     = vecs[v].lat;
         done_en = vecs[v].en;
         req     = N'(1) << vecs[v].rid;
         push_exp(N'(1) << vecs[v].rid, vecs[v].res, vecs[v].err);
         wait_ack(40, cyc, got);
         chk("latency", 32'(cyc), 32'(vecs[v].cyc));
         req = '0;
      end

      // reset while requester 1 is waiting on a stalled adder
      @(negedge clk);
      op_a[0*W +: W] = 8'h10;
      op_b[0*W +: W] = 8'h05;
      op_a[1*W +: W] = 8'h21;
      op_b[1*W +: W] = 8'h02;
      done_en = 1'b0;
      lat     = 0;
      req     = 4'b0010;
      push_exp(4'b0010, 8'h23, 1'b0);
      repeat (5) @(negedge clk);
      chk("mid_busy_before_reset", 32'(busy), 1);
      rst = 1'b1;
      #1 chk_reset("mid");
      sb.delete();
      req     = 4'b0011;
      done_en = 1'b1;
      push_exp(4'b0001, 8'h15, 1'b0);
      push_exp(4'b0010, 8'h23, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      wait_ack(40, cyc, got);
      chk("post_reset_latency", 32'(cyc), 4);
      req = req & ~got;
      wait_ack(40, cyc, got);
      req = req & ~got;

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
